// File: rtl/spi_3wire_peripheral.sv
// Target end of the 3-wire half-duplex SPI link (sck idles high, data sampled on sck rise).
// Receives bytes from the controller, then optionally turns DIO around and streams response bytes.
module spi_3wire_peripheral #(
    parameter int         SYNC_STAGES  = 2,
    parameter bit         LSB_FIRST    = 1'b0,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       dio_i,
    output logic       dio_o,
    output logic       dio_e,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       frame_end,
    output logic       frame_abort
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_TX   = 2'd2
    } state_t;

    state_t            state_r;
    logic [SYNC_N-1:0] sck_sync_r;
    logic [SYNC_N-1:0] cs_sync_r;
    logic [SYNC_N-1:0] dio_sync_r;
    logic              sck_prev_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        byte_cnt_r;
    logic [7:0]        rx_shift_r;
    logic [7:0]        tx_shift_r;

    logic sck_s;
    logic cs_s;
    logic dio_s;
    logic sck_rise_s;
    logic sck_fall_s;

    // Wire-order helpers shared by the receive and transmit paths.
    function automatic logic first_bit(input logic [7:0] b);
        return LSB_FIRST ? b[0] : b[7];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return LSB_FIRST ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] s, input logic d);
        return LSB_FIRST ? {d, s[7:1]} : {s[6:0], d};
    endfunction

    assign sck_s      = sck_sync_r[SYNC_N-1];
    assign cs_s       = cs_sync_r[SYNC_N-1];
    assign dio_s      = dio_sync_r[SYNC_N-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign busy       = ~cs_s;

    // Pad synchronizers plus the extra sck flop used for edge detection; reset to bus-idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_r <= {SYNC_N{1'b1}};
            cs_sync_r  <= {SYNC_N{1'b1}};
            dio_sync_r <= {SYNC_N{1'b1}};
            sck_prev_r <= 1'b1;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_N-2:0], sck};
            cs_sync_r  <= {cs_sync_r[SYNC_N-2:0], cs_n};
            dio_sync_r <= {dio_sync_r[SYNC_N-2:0], dio_i};
            sck_prev_r <= sck_s;
        end
    end

    // Frame FSM with all user-visible outputs registered; cs_n release takes priority over sck edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 8'd0;
            rx_shift_r  <= 8'd0;
            tx_shift_r  <= 8'd0;
            dio_o       <= 1'b1;
            dio_e       <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    dio_e <= 1'b0;
                    dio_o <= 1'b1;
                    if (!cs_s) begin
                        bit_cnt_r  <= 3'd0;
                        byte_cnt_r <= 8'd0;
                        rx_shift_r <= 8'd0;
                        state_r    <= S_RX;
                    end
                end
                S_RX: begin
                    if (cs_s) begin
                        dio_e       <= 1'b0;
                        dio_o       <= 1'b1;
                        frame_end   <= (bit_cnt_r == 3'd0);
                        frame_abort <= (bit_cnt_r != 3'd0);
                        state_r     <= S_IDLE;
                    end else if (sck_rise_s) begin
                        rx_shift_r <= shift_in(rx_shift_r, dio_s);
                        if (bit_cnt_r == 3'd7) begin
                            rx_data    <= shift_in(rx_shift_r, dio_s);
                            rx_valid   <= 1'b1;
                            rx_first   <= (byte_cnt_r == 8'd0);
                            byte_cnt_r <= (byte_cnt_r == 8'hFF) ? byte_cnt_r : byte_cnt_r + 8'd1;
                            bit_cnt_r  <= 3'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else if (sck_fall_s && (bit_cnt_r == 3'd0) && (byte_cnt_r != 8'd0) && tx_valid) begin
                        // Turnaround only when user logic already has a response ready at a byte boundary.
                        tx_shift_r <= shift_out(tx_data);
                        dio_o      <= first_bit(tx_data);
                        dio_e      <= 1'b1;
                        tx_ack     <= 1'b1;
                        state_r    <= S_TX;
                    end
                end
                S_TX: begin
                    if (cs_s) begin
                        dio_e       <= 1'b0;
                        dio_o       <= 1'b1;
                        frame_end   <= (bit_cnt_r == 3'd0);
                        frame_abort <= (bit_cnt_r != 3'd0);
                        state_r     <= S_IDLE;
                    end else if (sck_fall_s) begin
                        if (bit_cnt_r == 3'd0) begin
                            if (tx_valid) begin
                                tx_shift_r <= shift_out(tx_data);
                                dio_o      <= first_bit(tx_data);
                                tx_ack     <= 1'b1;
                            end else begin
                                tx_shift_r <= shift_out(IDLE_TX_BYTE);
                                dio_o      <= first_bit(IDLE_TX_BYTE);
                            end
                        end else begin
                            tx_shift_r <= shift_out(tx_shift_r);
                            dio_o      <= first_bit(tx_shift_r);
                        end
                    end else if (sck_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                end
                default: begin
                    dio_e   <= 1'b0;
                    dio_o   <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_3wire_peripheral.sv
// Scoreboard bench: a bit-banged controller drives frames, expected bytes are queued at stimulus
// time and popped when the peripheral emits rx_valid or when the controller finishes reading a byte.
`timescale 1ns/1ps
module tb_spi_3wire_peripheral;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b1;
    logic       cs_n = 1'b1;
    logic       ctl_dio = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data2 = 8'd0;
    logic       tx_valid2 = 1'b0;

    logic       dio_o, dio_e, busy, rx_valid, rx_first, tx_ack, frame_end, frame_abort;
    logic [7:0] rx_data;
    logic       dio_o2, dio_e2, busy2, rx_valid2, rx_first2, tx_ack2, frame_end2, frame_abort2;
    logic [7:0] rx_data2;

    int total = 0;
    int bad = 0;
    int n_end = 0, n_abort = 0, n_ack = 0, n_ack2 = 0, n_end2 = 0;
    bit dioe_seen = 1'b0;
    bit mon_msb = 1'b0;
    bit mon_lsb = 1'b0;

    logic [8:0] rx_exp[$];
    logic [8:0] rx_exp2[$];
    logic [7:0] rd_exp[$];
    logic [7:0] resp_q[$];
    logic [7:0] resp2_q[$];
    logic [8:0] exp_rx;
    logic [7:0] w;

    always #5 clk = ~clk;

    spi_3wire_peripheral #(.SYNC_STAGES(2), .LSB_FIRST(1'b0), .IDLE_TX_BYTE(8'hFF)) u_dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .dio_i(ctl_dio),
        .dio_o(dio_o), .dio_e(dio_e), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
        .frame_end(frame_end), .frame_abort(frame_abort)
    );

    spi_3wire_peripheral #(.SYNC_STAGES(2), .LSB_FIRST(1'b1), .IDLE_TX_BYTE(8'hFF)) u_dut_lsb (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .dio_i(ctl_dio),
        .dio_o(dio_o2), .dio_e(dio_e2), .busy(busy2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_first(rx_first2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ack(tx_ack2),
        .frame_end(frame_end2), .frame_abort(frame_abort2)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors, pulse counters and the user-side responder that pops on tx_ack.
    always @(negedge clk) begin
        if (mon_msb && rx_valid) begin
            if (rx_exp.size() == 0) begin
                check_value("rx_unexpected", {23'd0, rx_first, rx_data}, 32'h200);
            end else begin
                exp_rx = rx_exp.pop_front();
                check_value("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, exp_rx});
            end
        end
        if (mon_lsb && rx_valid2) begin
            if (rx_exp2.size() == 0) begin
                check_value("rx_unexpected_lsb", {23'd0, rx_first2, rx_data2}, 32'h200);
            end else begin
                exp_rx = rx_exp2.pop_front();
                check_value("rx_byte_lsb", {23'd0, rx_first2, rx_data2}, {23'd0, exp_rx});
            end
        end
        if (frame_end)   n_end++;
        if (frame_abort) n_abort++;
        if (tx_ack)      n_ack++;
        if (dio_e)       dioe_seen = 1'b1;
        if (tx_ack2)     n_ack2++;
        if (frame_end2)  n_end2++;
        if (tx_ack && resp_q.size() > 0)   void'(resp_q.pop_front());
        if (tx_ack2 && resp2_q.size() > 0) void'(resp2_q.pop_front());
        tx_valid  = (resp_q.size() > 0);
        tx_data   = (resp_q.size() > 0) ? resp_q[0] : 8'd0;
        tx_valid2 = (resp2_q.size() > 0);
        tx_data2  = (resp2_q.size() > 0) ? resp2_q[0] : 8'd0;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        n_end = 0; n_abort = 0; n_ack = 0; n_ack2 = 0; n_end2 = 0; dioe_seen = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_n(HALF);
    endtask

    task automatic frame_close();
        wait_n(HALF);
        cs_n = 1'b1;
        ctl_dio = 1'b1;
        wait_n(12);
    endtask

    task automatic ctl_write(input logic [7:0] b, input bit lsb, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            ctl_dio = lsb ? b[i] : b[7-i];
            wait_n(HALF);
            sck = 1'b1;
            wait_n(HALF);
        end
    endtask

    // Bits are assembled in wire order: the first bit seen ends up in the MSB of a full byte.
    task automatic ctl_read(input bit sel, input int nbits, output logic [7:0] wb);
        wb = 8'd0;
        ctl_dio = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            wait_n(HALF);
            check_value(sel ? "rd_dioe_lsb" : "rd_dioe", {31'd0, sel ? dio_e2 : dio_e}, 32'd1);
            wb = {wb[6:0], sel ? dio_o2 : dio_o};
            sck = 1'b1;
            wait_n(HALF);
        end
    endtask

    task automatic read_and_score();
        logic [7:0] got;
        ctl_read(1'b0, 8, got);
        if (rd_exp.size() == 0) begin
            check_value("rd_unexpected", {24'd0, got}, 32'h100);
        end else begin
            check_value("rd_byte", {24'd0, got}, {24'd0, rd_exp.pop_front()});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_n(5);
        check_value("rst_dio_o", {31'd0, dio_o}, 32'd1);
        check_value("rst_dio_e", {31'd0, dio_e}, 32'd0);
        check_value("rst_busy", {30'd0, busy, busy2}, 32'd0);
        check_value("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check_value("rst_pulses", {27'd0, rx_valid, rx_first, tx_ack, frame_end, frame_abort}, 32'd0);
        reset = 1'b0;
        wait_n(5);
        mon_msb = 1'b1;

        // Plain write frame.
        clear_counts();
        rx_exp.push_back({1'b1, 8'hA5});
        rx_exp.push_back({1'b0, 8'h3C});
        rx_exp.push_back({1'b0, 8'h81});
        frame_begin();
        check_value("busy_in_frame", {31'd0, busy}, 32'd1);
        ctl_write(8'hA5, 1'b0, 8);
        ctl_write(8'h3C, 1'b0, 8);
        ctl_write(8'h81, 1'b0, 8);
        frame_close();
        check_value("wr_rx_left", rx_exp.size(), 32'd0);
        check_value("wr_frame_end", n_end, 32'd1);
        check_value("wr_abort", n_abort, 32'd0);
        check_value("wr_dioe_seen", {31'd0, dioe_seen}, 32'd0);
        check_value("wr_busy_after", {31'd0, busy}, 32'd0);

        // Write one byte, then read two responses.
        clear_counts();
        rx_exp.push_back({1'b1, 8'h42});
        resp_q.push_back(8'hDE);
        resp_q.push_back(8'hAD);
        rd_exp.push_back(8'hDE);
        rd_exp.push_back(8'hAD);
        wait_n(2);
        frame_begin();
        ctl_write(8'h42, 1'b0, 8);
        read_and_score();
        read_and_score();
        frame_close();
        check_value("wr_rd_ack", n_ack, 32'd2);
        check_value("wr_rd_end", n_end, 32'd1);
        check_value("wr_rd_dioe_after", {31'd0, dio_e}, 32'd0);
        check_value("wr_rd_rx_left", rx_exp.size(), 32'd0);

        // Underrun: one response supplied, three read.
        clear_counts();
        rx_exp.push_back({1'b1, 8'h0F});
        resp_q.push_back(8'h12);
        rd_exp.push_back(8'h12);
        rd_exp.push_back(8'hFF);
        rd_exp.push_back(8'hFF);
        wait_n(2);
        frame_begin();
        ctl_write(8'h0F, 1'b0, 8);
        read_and_score();
        read_and_score();
        read_and_score();
        frame_close();
        check_value("udr_ack", n_ack, 32'd1);
        check_value("udr_end", n_end, 32'd1);

        // Abort after five bits.
        clear_counts();
        frame_begin();
        ctl_write(8'hF0, 1'b0, 5);
        frame_close();
        check_value("abort_pulse", n_abort, 32'd1);
        check_value("abort_end", n_end, 32'd0);
        check_value("abort_busy", {31'd0, busy}, 32'd0);
        check_value("abort_dioe", {31'd0, dio_e}, 32'd0);

        // LSB-first instance: receive 0x01, answer 0x80 (wire sees 0 x7 then 1).
        clear_counts();
        mon_msb = 1'b0;
        mon_lsb = 1'b1;
        rx_exp2.push_back({1'b1, 8'h01});
        resp2_q.push_back(8'h80);
        wait_n(2);
        frame_begin();
        ctl_write(8'h01, 1'b1, 8);
        ctl_read(1'b1, 8, w);
        check_value("lsb_wire", {24'd0, w}, 32'h01);
        frame_close();
        check_value("lsb_rx_left", rx_exp2.size(), 32'd0);
        check_value("lsb_ack", n_ack2, 32'd1);
        check_value("lsb_end", n_end2, 32'd1);
        mon_lsb = 1'b0;
        mon_msb = 1'b1;

        // Reset while the response is on the wire.
        clear_counts();
        rx_exp.push_back({1'b1, 8'h55});
        resp_q.push_back(8'hC3);
        wait_n(2);
        frame_begin();
        ctl_write(8'h55, 1'b0, 8);
        ctl_read(1'b0, 3, w);
        check_value("rst_tx_bits", {29'd0, w[2:0]}, 32'd6);
        sck = 1'b0;
        wait_n(HALF / 2);
        reset = 1'b1;
        wait_n(1);
        check_value("rst_tx_dio_e", {31'd0, dio_e}, 32'd0);
        check_value("rst_tx_dio_o", {31'd0, dio_o}, 32'd1);
        check_value("rst_tx_pulses", {28'd0, rx_valid, tx_ack, frame_end, frame_abort}, 32'd0);
        check_value("rst_tx_lsb_pulses", {29'd0, tx_ack2, frame_end2, frame_abort2}, 32'd0);
        resp_q.delete();
        cs_n = 1'b1;
        sck = 1'b1;
        ctl_dio = 1'b1;
        wait_n(6);
        reset = 1'b0;
        wait_n(10);
        check_value("rst_tx_ack", n_ack, 32'd1);
        check_value("rst_tx_no_end", n_end + n_abort, 32'd0);
        check_value("rst_tx_idle", {30'd0, busy, dio_e}, 32'd0);
        check_value("final_rx_left", rx_exp.size(), 32'd0);
        check_value("final_rd_left", rd_exp.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_3wire_peripheral.md
# spi_3wire_peripheral

Peripheral (target) end of the team's 3-wire half-duplex SPI link: clock idles high, MSB first, data sampled on sck rising edge, shared DIO line. It oversamples sck/cs_n/dio with the system clock, and delivers each received byte to user logic with a valid pulse. When user logic supplies response bytes, it turns the DIO line around and drives them back on sck falling edges. It sits in an FPGA acting as a target for our SPI controller, or as an emulation model for HT16D35A/TM1638-style parts in system benches.

## Interface
- SYNC_STAGES, 2: synchronizer flops on sck, cs_n, dio_i (min 2).
- LSB_FIRST, 0: 1 = bit 0 transferred first in both directions.
- IDLE_TX_BYTE, 8'hFF: byte driven when in TX and no tx_valid at byte start.
- clk  in  1  system clock; sck half-period must be >= SYNC_STAGES+3 clk cycles.
- reset  in  1  synchronous, active-high.
- sck  in  1  SPI clock from controller (idles high).
- cs_n  in  1  chip select, active low.
- dio_i  in  1  DIO pad input.
- dio_o  out  1  DIO pad output value.
- dio_e  out  1  DIO pad output enable.
- busy  out  1  high while synchronized cs_n is low.
- rx_data  out  8  last received byte; holds until next rx_valid.
- rx_valid  out  1  one-cycle pulse, rx_data new.
- rx_first  out  1  qualifies rx_valid: byte is first of the frame.
- tx_data  in  8  response byte.
- tx_valid  in  1  level: response byte available.
- tx_ack  out  1  one-cycle pulse: tx_data consumed.
- frame_end  out  1  one-cycle pulse at cs_n deassert after whole bytes.
- frame_abort  out  1  one-cycle pulse at cs_n deassert mid-byte.

## Operation
- Inputs pass through SYNC_STAGES flops; one further flop on sck gives edge detect (rise = prev 0, now 1; fall = prev 1, now 0). All decisions use synchronized values only.
- States: S_IDLE, S_RX, S_TX.
- S_IDLE: dio_e=0. On synced cs_n low: bit_cnt=0, byte_cnt=0, shift=0 -> S_RX.
- S_RX: on sck rise, shift in synced dio_i (MSB first unless LSB_FIRST), bit_cnt++. On 8th bit: rx_data<=assembled byte, rx_valid=1, rx_first=(byte_cnt==0), byte_cnt++ (saturating), bit_cnt=0.
- Turnaround: on an sck fall in S_RX with bit_cnt==0 and byte_cnt!=0, if tx_valid=1: load tx_data, tx_ack=1, dio_e=1, dio_o=first bit -> S_TX. If tx_valid=0 stay in S_RX (controller still writing).
- S_TX: on each sck fall, drive next bit. At byte start (bit_cnt==0) load tx_data with tx_ack if tx_valid, else IDLE_TX_BYTE with no ack. On sck rise bit_cnt++ (wrap 7->0). dio_e stays 1 until frame end; no rx_valid in S_TX.
- Once in S_TX, frame never returns to S_RX.
- cs_n deassert (synced rising) from S_RX/S_TX: dio_e=0 next cycle, -> S_IDLE; frame_end if bit_cnt==0, else frame_abort, partial byte discarded, no rx_valid.
- cs_n deassert on same cycle as sck edge: cs_n wins; edge ignored.
- tx_valid ignored outside byte-start falls in S_RX/S_TX; tx_ack only on load.
- reset (any time, including mid-frame): state S_IDLE, all outputs 0 (dio_o=1), counters 0, sync flops to idle (sck=1, cs_n=1, dio=1). After reset, a frame already in progress (cs_n low) is treated as starting at the next cycle: entry to S_RX — bench avoids this.

## Timing
- Reset values: dio_o=1, dio_e=0, busy=0, rx_data=0, rx_valid=0, rx_first=0, tx_ack=0, frame_end=0, frame_abort=0.
- Pin-to-event latency = SYNC_STAGES+1 clk: sck rise pin -> rx_valid; sck fall pin -> dio_o/dio_e update, same cycle as tx_ack.
- Controller samples just before rising edge, one half-bit after falling edge; half-bit >= SYNC_STAGES+3 guarantees setup (CLK_DIV=16 at 50 MHz gives 8).
- User must assert tx_valid within one inter-byte gap of rx_valid (before next sck fall is detected) to turn around on that byte.
- busy follows synced cs_n with SYNC_STAGES latency.

## Test plan
- Write frame: cs low, bytes 0xA5,0x3C,0x81 MSB first -> rx_valid x3 with 0xA5 (rx_first=1),0x3C,0x81; frame_end once; dio_e=0 throughout.
- Write-then-read: send 0x42, user asserts tx_valid/tx_data=0xDE then 0xAD on each tx_ack, controller reads 2 bytes -> controller gets 0xDE,0xAD; tx_ack x2; dio_e 1 from first read fall to cs high.
- Underrun: read 3 bytes with only 0x12 supplied -> 0x12,0xFF,0xFF; tx_ack once.
- Abort: cs_n high after 5 bits of 0xF0 -> no rx_valid, frame_abort=1 one cycle, state S_IDLE.
- LSB_FIRST=1: send 0x01 (bit0 first) -> rx_data=0x01; response 0x80 observed on wire as 0,0,...,1.
- Reset mid-TX: assert reset at bit 3 of response -> dio_e=0, dio_o=1 next cycle, all pulses 0, no tx_ack.
